ysyx_24100006_uart_fifo: RTL and testbench



---
 rtl/ysyx_24100006_uart_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_ysyx_24100006_uart_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_uart_fifo.sv
// AXI-Lite simulation UART: TX FIFO, paced drain engine, line-status reg.
// Bytes stored to THR are emitted every TX_CYCLES clocks via $write/strobe.
module ysyx_24100006_uart_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'ha000_03f8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TX_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] axi_araddr,
  input  logic [31:0] axi_awaddr,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  output logic        tx_valid,
  output logic [7:0]  tx_data
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW =
    (TX_CYCLES > 1) ? $clog2(TX_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] RELOAD_C = BW'(TX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WPUSH,
    S_WRESP
  } state_e;

  state_e        state_q, state_d;
  logic          arready_q, arready_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          w_in_q, w_in_d;
  logic          w_thr_q, w_thr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wstrb0_q, wstrb0_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [BW-1:0] busy_q;
  logic          txv_q;
  logic [7:0]    txd_q;

  logic          push;
  logic          pop;
  logic          full;
  logic          need_push;
  logic [31:0]   r_off;
  logic [31:0]   w_off;
  logic          r_in;
  logic          r_lsr;
  logic [31:0]   lsr;
  logic          unused_bits;

  assign unused_bits = ^{axi_wdata[31:8], axi_wstrb[3:1]};

  assign r_off = axi_araddr - BASE_ADDR;
  assign w_off = axi_awaddr - BASE_ADDR;
  assign r_in  = (r_off < 32'd8);
  assign r_lsr = r_in && r_off[2];

  assign full = (count_q == FULL_C);
  assign pop  = (busy_q == '0) && (count_q != '0);

  assign lsr = {17'd0,
                (count_q == '0) && (busy_q == '0),
                !full,
                13'd0};

  assign need_push = w_in_q && w_thr_q && wstrb0_q;

  // Bus FSM: next state, registered handshake and response values
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_in_d    = w_in_q;
    w_thr_d   = w_thr_q;
    wdata_d   = wdata_q;
    wstrb0_d  = wstrb0_q;
    push      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (axi_arvalid) begin
          arready_d = 1'b1;
          state_d   = S_RADDR;
        end else if (axi_awvalid && axi_wvalid) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
          state_d   = S_WADDR;
        end
      end
      S_RADDR: begin
        arready_d = 1'b0;
        if (axi_arvalid) begin
          rdata_d  = r_lsr ? lsr : 32'd0;
          rresp_d  = r_in ? 2'b00 : 2'b10;
          rvalid_d = 1'b1;
          state_d  = S_RDATA;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RDATA: begin
        if (axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_WADDR: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (axi_awvalid && axi_wvalid) begin
          w_in_d   = (w_off < 32'd8);
          w_thr_d  = (w_off == 32'd0);
          wdata_d  = axi_wdata[7:0];
          wstrb0_d = axi_wstrb[0];
          state_d  = S_WPUSH;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WPUSH: begin
        if (!(need_push && full)) begin
          push     = need_push;
          bvalid_d = 1'b1;
          bresp_d  = w_in_q ? 2'b00 : 2'b10;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        arready_d = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        rvalid_d  = 1'b0;
        bvalid_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Bus FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      w_in_q    <= 1'b0;
      w_thr_q   <= 1'b0;
      wdata_q   <= 8'd0;
      wstrb0_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      w_in_q    <= w_in_d;
      w_thr_q   <= w_thr_d;
      wdata_q   <= wdata_d;
      wstrb0_q  <= wstrb0_d;
    end
  end

  // FIFO storage; contents need no reset, pointers guard them
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata_q;
    end
  end

  // Pointers, occupancy and paced drain
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      txv_q   <= 1'b0;
      txd_q   <= 8'd0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        txv_q  <= 1'b1;
        txd_q  <= mem_q[rptr_q];
        busy_q <= RELOAD_C;
        $write("%c", mem_q[rptr_q]);
      end else begin
        txv_q <= 1'b0;
        if (busy_q != '0) begin
          busy_q <= busy_q - BW'(1);
        end
      end
    end
  end

  assign axi_arready = arready_q;
  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign tx_valid    = txv_q;
  assign tx_data     = txd_q;

endmodule

// File: tb/tb_ysyx_24100006_uart_fifo.sv
// Scoreboard bench for ysyx_24100006_uart_fifo: queued expectations,
// independent negedge monitor, randomized traffic on top of directed cases.
module tb_ysyx_24100006_uart_fifo;

  localparam logic [31:0] BASE = 32'ha000_03f8;
  localparam int TXC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] axi_araddr = '0;
  logic [31:0] axi_awaddr = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic        axi_rvalid;
  logic        axi_rready = 1'b1;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic        axi_bvalid;
  logic        axi_bready = 1'b1;
  logic [1:0]  axi_bresp;
  logic        tx_valid;
  logic [7:0]  tx_data;

  ysyx_24100006_uart_fifo dut (
    .clk(clk), .reset(reset),
    .axi_araddr(axi_araddr), .axi_awaddr(axi_awaddr),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_bresp(axi_bresp),
    .tx_valid(tx_valid), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_tx[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  int last_tx = -1;
  int tx_cnt = 0;
  bit burst = 1'b0;
  logic prev_aw = 1'b0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d", nm, got, want, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s timed out @cyc %0d", nm, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid) begin
        if (exp_tx.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected got=%0h want=none", tx_data);
        end else begin
          check("tx_data", tx_data, exp_tx.pop_front());
        end
        if (last_tx >= 0) begin
          if (burst) check("tx_gap", cyc - last_tx, TXC);
          else check("tx_gap_min", (cyc - last_tx) >= TXC, 1);
        end
        last_tx = cyc;
        tx_cnt++;
      end
      if (axi_bvalid && axi_bready) begin
        if (exp_b.size() == 0) timeout("bresp_unexpected");
        else check("bresp", axi_bresp, exp_b.pop_front());
      end
      if (axi_rvalid && axi_rready) begin
        if (exp_r.size() == 0) timeout("rresp_unexpected");
        else check("rresp_rdata", {axi_rresp, axi_rdata},
                   exp_r.pop_front());
      end
      if (axi_awready) check("awready_pulse", prev_aw, 0);
      prev_aw = axi_awready;
    end else begin
      prev_aw = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_tx.delete();
    exp_b.delete();
    exp_r.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {axi_arready, axi_awready, axi_wready, axi_rvalid,
           axi_bvalid, tx_valid, axi_rdata, axi_rresp,
           axi_bresp, tx_data}, 64'd0);
    reset = 1'b0;
    last_tx = -1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output int t0, output int lat);
    int n;
    logic [31:0] off;
    off = a - BASE;
    @(posedge clk); #1;
    axi_awaddr = a;
    axi_wdata = d;
    axi_wstrb = s;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    t0 = cyc;
    lat = -1;
    exp_b.push_back(off < 8 ? 2'b00 : 2'b10);
    if (off == 0 && s[0]) exp_tx.push_back(d[7:0]);
    n = 0;
    while (!axi_awready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!axi_awready) begin
      timeout("awready");
      axi_awvalid = 1'b0;
      axi_wvalid = 1'b0;
      return;
    end
    check("aw_latency", cyc - t0, 1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    n = 0;
    while (!axi_bvalid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!axi_bvalid) begin
      timeout("bvalid");
      return;
    end
    lat = cyc - t0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [33:0] want);
    int n, t0;
    @(posedge clk); #1;
    axi_araddr = a;
    axi_arvalid = 1'b1;
    t0 = cyc;
    exp_r.push_back(want);
    n = 0;
    while (!axi_arready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!axi_arready) begin
      timeout("arready");
      axi_arvalid = 1'b0;
      return;
    end
    check("ar_latency", cyc - t0, 1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!axi_rvalid) begin
      timeout("rvalid");
      return;
    end
    check("r_latency", cyc - t0, 2);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("drain_done", exp_tx.size(), 0);
    repeat (TXC + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired @cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, snap, stalls, n;
    logic [31:0] a;
    logic [7:0] hello [5];
    hello[0] = "h"; hello[1] = "e"; hello[2] = "l";
    hello[3] = "l"; hello[4] = "o";

    do_reset();
    rd(BASE + 5, {2'b00, 32'h0000_6000});
    rd(BASE + 4, {2'b00, 32'h0000_6000});

    wr(BASE, 32'h41, 4'b0001, t0, lat);
    check("single_b_latency", lat, 3);
    rd(BASE + 5, {2'b00, 32'h0000_2000});
    check("single_tx_time", last_tx, t0 + 4);
    repeat (TXC + 4) @(posedge clk);
    #1;
    rd(BASE + 5, {2'b00, 32'h0000_6000});
    rd(BASE, {2'b00, 32'h0});

    snap = tx_cnt;
    rd(32'ha000_0400, {2'b10, 32'h0});
    rd(BASE + 1, {2'b00, 32'h0});
    wr(32'ha000_0400, 32'h55, 4'b1111, t0, lat);
    wr(32'ha000_03f9, 32'h56, 4'b1111, t0, lat);
    wr(BASE, 32'h57, 4'b1110, t0, lat);
    repeat (40) @(posedge clk);
    #1;
    check("no_push_errors", tx_cnt, snap);

    burst = 1'b1;
    last_tx = -1;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      wr(BASE, 32'h30 + i, 4'b0001, t0, lat);
      if (lat > 3) begin
        stalls++;
        check("bvalid_after_pop", t0 + lat, last_tx + 1);
      end
    end
    check("saw_backpressure", stalls > 0, 1);
    wait_drain();
    burst = 1'b0;
    rd(BASE + 5, {2'b00, 32'h0000_6000});

    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 9));
      if (n < 3) begin
        if ($urandom_range(0, 1) == 0) begin
          a = BASE + $urandom_range(0, 3);
          rd(a, {2'b00, 32'h0});
        end else begin
          a = BASE + 8 + $urandom_range(0, 64);
          rd(a, {2'b10, 32'h0});
        end
      end else begin
        if (n < 8) a = BASE;
        else if (n == 8) a = BASE + $urandom_range(1, 7);
        else a = BASE - 4 * $urandom_range(1, 8);
        wr(a, $urandom_range(97, 122), 4'($urandom_range(0, 15)),
           t0, lat);
      end
    end
    wait_drain();
    rd(BASE + 5, {2'b00, 32'h0000_6000});

    snap = tx_cnt;
    for (int i = 0; i < 5; i++) begin
      wr(BASE, {24'd0, hello[i]}, 4'b0001, t0, lat);
    end
    n = 0;
    while (tx_cnt < snap + 2 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("two_tx_before_reset", tx_cnt, snap + 2);
    do_reset();
    snap = tx_cnt;
    repeat (60) @(posedge clk);
    #1;
    check("no_tx_after_reset", tx_cnt, snap);
    rd(BASE + 5, {2'b00, 32'h0000_6000});

    repeat (4) @(posedge clk);
    check("scoreboard_empty",
          exp_tx.size() + exp_b.size() + exp_r.size(), 0);
    $display("");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
